key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 109 ++++++++++
 tb/tb_key_conditioner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key 2-flop synchronizer, debounce FSM, and
// registered level / press / release / toggle outputs.
module key_conditioner #(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  // The accepting edge itself is the final stable sample, so the wait
  // state hands over one count early.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_KEYS-1:0] RELEASED = KEY_ACTIVE_LOW ? {NUM_KEYS{1'b1}} : {NUM_KEYS{1'b0}};

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [NUM_KEYS-1:0] sync0;
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] pressed_c;
  state_t              state [NUM_KEYS];
  logic [CNT_W-1:0]    cnt   [NUM_KEYS];

  assign pressed_c = KEY_ACTIVE_LOW ? ~sync1 : sync1;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0       <= RELEASED;
      sync1       <= RELEASED;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_toggle  <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        state[k] <= IDLE;
        cnt[k]   <= '0;
      end
    end else begin
      sync0       <= key_raw;
      sync1       <= sync0;
      key_press   <= '0;
      key_release <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        case (state[k])
          IDLE: begin
            if (pressed_c[k]) begin
              state[k] <= PRESS_WAIT;
              cnt[k]   <= CNT_W'(1);
            end else begin
              cnt[k]   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!pressed_c[k]) begin
              state[k] <= IDLE;
              cnt[k]   <= '0;
            end else if (cnt[k] >= CNT_LAST) begin
              state[k]      <= PRESSED;
              cnt[k]        <= '0;
              key_level[k]  <= 1'b1;
              key_press[k]  <= 1'b1;
              key_toggle[k] <= ~key_toggle[k];
            end else begin
              cnt[k]   <= cnt[k] + CNT_W'(1);
            end
          end
          PRESSED: begin
            if (!pressed_c[k]) begin
              state[k] <= RELEASE_WAIT;
              cnt[k]   <= CNT_W'(1);
            end else begin
              cnt[k]   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (pressed_c[k]) begin
              state[k] <= PRESSED;
              cnt[k]   <= '0;
            end else if (cnt[k] >= CNT_LAST) begin
              state[k]       <= IDLE;
              cnt[k]         <= '0;
              key_level[k]   <= 1'b0;
              key_release[k] <= 1'b1;
            end else begin
              cnt[k]   <= cnt[k] + CNT_W'(1);
            end
          end
          default: begin
            state[k] <= IDLE;
            cnt[k]   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus random
// bouncing keys compared against a run-length reference model.
module tb_key_conditioner;

  localparam int unsigned NK  = 2;
  localparam int unsigned DEB = 4;
  localparam int          THRESH = (DEB < 2) ? 2 : DEB;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release, key_toggle;

  int tests = 0;
  int fails = 0;

  key_conditioner #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DEB),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_raw(key_raw),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .key_toggle(key_toggle)
  );

  always #5 clk = ~clk;

  // Reference: two-stage delay of the raw levels, then a key changes once it
  // has disagreed with its accepted level for THRESH consecutive edges.
  logic [NK-1:0] m_s0, m_s1;
  logic [NK-1:0] exp_level, exp_press, exp_release, exp_toggle;
  int            m_run [NK];

  always @(posedge clk) begin
    logic [NK-1:0] s;
    if (reset) begin
      m_s0 = '1;
      m_s1 = '1;
      exp_level = '0; exp_press = '0; exp_release = '0; exp_toggle = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
    end else begin
      s = ~m_s1;
      exp_press = '0;
      exp_release = '0;
      for (int k = 0; k < NK; k++) begin
        if (s[k] != exp_level[k]) begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] >= THRESH) begin
            m_run[k] = 0;
            exp_level[k] = s[k];
            if (s[k]) begin
              exp_press[k] = 1'b1;
              exp_toggle[k] = ~exp_toggle[k];
            end else begin
              exp_release[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
      m_s1 = m_s0;
      m_s0 = key_raw;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_raw = 2'b11;
    repeat (3) step();
    tests++;
    if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
      fails++;
      $display("FAIL reset_state: got lvl=%b prs=%b rel=%b tog=%b, expected all 0",
               key_level, key_press, key_release, key_toggle);
    end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      tests++;
      if ({key_level, key_press, key_release, key_toggle} !== 8'h00) begin
        fails++;
        $display("FAIL idle_hold cycle %0d: got lvl=%b prs=%b rel=%b tog=%b, expected all 0",
                 i, key_level, key_press, key_release, key_toggle);
      end
    end
  endtask

  task automatic test_press_release();
    logic el, ep;
    key_raw[0] = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      el = (e >= 6);
      ep = (e == 6);
      tests++;
      if (key_level[0] !== el || key_press[0] !== ep || key_release[0] !== 1'b0) begin
        fails++;
        $display("FAIL press_edge %0d: got lvl=%b prs=%b rel=%b, expected lvl=%b prs=%b rel=0",
                 e, key_level[0], key_press[0], key_release[0], el, ep);
      end
    end
    tests++;
    if (key_toggle[0] !== 1'b1) begin
      fails++;
      $display("FAIL press_toggle: got %b, expected 1", key_toggle[0]);
    end
    key_raw[0] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      el = (e < 6);
      ep = (e == 6);
      tests++;
      if (key_level[0] !== el || key_release[0] !== ep || key_press[0] !== 1'b0) begin
        fails++;
        $display("FAIL release_edge %0d: got lvl=%b rel=%b prs=%b, expected lvl=%b rel=%b prs=0",
                 e, key_level[0], key_release[0], key_press[0], el, ep);
      end
    end
    tests++;
    if (key_toggle[0] !== 1'b1) begin
      fails++;
      $display("FAIL release_toggle: got %b, expected 1", key_toggle[0]);
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        key_raw[1] = (i >= 3);
        step();
        tests++;
        if ({key_level[1], key_press[1], key_release[1], key_toggle[1]} !== 4'b0000) begin
          fails++;
          $display("FAIL bounce rep %0d cyc %0d: got lvl=%b prs=%b rel=%b tog=%b, expected 0000",
                   r, i, key_level[1], key_press[1], key_release[1], key_toggle[1]);
        end
      end
    end
    repeat (4) step();
    tests++;
    if (key_level[1] !== 1'b0) begin
      fails++;
      $display("FAIL bounce_settle: got lvl=%b, expected 0", key_level[1]);
    end
  endtask

  task automatic test_simultaneous();
    reset = 1'b1;
    key_raw = 2'b11;
    step();
    reset = 1'b0;
    repeat (3) step();
    key_raw = 2'b00;
    for (int e = 1; e <= 7; e++) begin
      step();
      tests++;
      if (key_press !== ((e == 6) ? 2'b11 : 2'b00)) begin
        fails++;
        $display("FAIL simul_press edge %0d: got %b, expected %b",
                 e, key_press, (e == 6) ? 2'b11 : 2'b00);
      end
    end
    key_raw = 2'b11;
    repeat (8) step();
    key_raw[0] = 1'b0;
    repeat (8) step();
    key_raw[0] = 1'b1;
    repeat (8) step();
    tests++;
    if (key_toggle !== 2'b10 || key_level !== 2'b00) begin
      fails++;
      $display("FAIL double_toggle: got tog=%b lvl=%b, expected tog=10 lvl=00",
               key_toggle, key_level);
    end
  endtask

  task automatic test_reset_abort();
    key_raw = 2'b11;
    repeat (8) step();
    key_raw[0] = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    tests++;
    if (key_press[0] !== 1'b0 || key_level[0] !== 1'b0) begin
      fails++;
      $display("FAIL abort_in_reset: got prs=%b lvl=%b, expected 0 0", key_press[0], key_level[0]);
    end
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      tests++;
      if (key_press[0] !== (e == 6) || key_level[0] !== (e >= 6)) begin
        fails++;
        $display("FAIL redebounce edge %0d: got prs=%b lvl=%b, expected prs=%b lvl=%b",
                 e, key_press[0], key_level[0], (e == 6), (e >= 6));
      end
    end
    key_raw = 2'b11;
    repeat (8) step();
  endtask

  task automatic test_random();
    int hold [NK];
    int bad = 0;
    for (int k = 0; k < NK; k++) hold[k] = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int k = 0; k < NK; k++) begin
        if (hold[k] == 0) begin
          key_raw[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
        end else begin
          hold[k]--;
        end
      end
      step();
      tests++;
      if (key_level !== exp_level || key_press !== exp_press ||
          key_release !== exp_release || key_toggle !== exp_toggle ||
          (key_press & key_release) !== 2'b00) begin
        fails++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc %0d: got lvl=%b prs=%b rel=%b tog=%b, expected lvl=%b prs=%b rel=%b tog=%b",
                   c, key_level, key_press, key_release, key_toggle,
                   exp_level, exp_press, exp_release, exp_toggle);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    key_raw = 2'b11;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
